// File: rtl/dual_port_ram_ctrl_if.sv
// Bus bundle for dual_port_ram_ctrl: clear control plus two independent req/ready RAM ports.
interface dual_port_ram_ctrl_if #(
    parameter int ADDRESS_SIZE = 4,
    parameter int WORD_SIZE    = 32
);
    localparam int NBYTES = WORD_SIZE / 8;

    logic                    clr;
    logic                    busy;

    logic                    a_req;
    logic                    a_we;
    logic [NBYTES-1:0]       a_be;
    logic [ADDRESS_SIZE-1:0] a_addr;
    logic [WORD_SIZE-1:0]    a_wdata;
    logic                    a_ready;
    logic [WORD_SIZE-1:0]    a_rdata;
    logic                    a_rvalid;

    logic                    b_req;
    logic                    b_we;
    logic [NBYTES-1:0]       b_be;
    logic [ADDRESS_SIZE-1:0] b_addr;
    logic [WORD_SIZE-1:0]    b_wdata;
    logic                    b_ready;
    logic [WORD_SIZE-1:0]    b_rdata;
    logic                    b_rvalid;

    modport master (
        output clr, a_req, a_we, a_be, a_addr, a_wdata, b_req, b_we, b_be, b_addr, b_wdata,
        input  busy, a_ready, a_rdata, a_rvalid, b_ready, b_rdata, b_rvalid
    );

    modport slave (
        input  clr, a_req, a_we, a_be, a_addr, a_wdata, b_req, b_we, b_be, b_addr, b_wdata,
        output busy, a_ready, a_rdata, a_rvalid, b_ready, b_rdata, b_rvalid
    );
endinterface

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port byte-enabled word RAM with read-first registered reads and a
// one-word-per-cycle clear sweep started by clr or by reset release.
module dual_port_ram_ctrl #(
    parameter int ADDRESS_SIZE   = 4,
    parameter int WORD_SIZE      = 32,
    parameter int CLEAR_ON_RESET = 1,
    parameter int A_PRIORITY     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_port_ram_ctrl_if.slave   bus
);
    localparam int DEPTH  = 1 << ADDRESS_SIZE;
    localparam int NBYTES = WORD_SIZE / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SWEEP} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDRESS_SIZE-1:0] r_cnt;
    logic                    w_busy;
    logic                    w_ready;

    logic                    w_a_wr, w_a_rd, w_b_wr, w_b_rd;
    logic [NBYTES-1:0]       w_a_mask, w_b_mask;
    logic [NBYTES-1:0]       w_hi_mask, w_lo_mask;
    logic [ADDRESS_SIZE-1:0] w_hi_addr, w_lo_addr;
    logic [WORD_SIZE-1:0]    w_hi_wdata, w_lo_wdata;
    logic [NBYTES-1:0][7:0]  w_a_rdata, w_b_rdata;
    logic                    r_a_rvalid, r_b_rvalid;

    // ST_INIT is the one-cycle gap between reset release and the automatic sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clr) w_state_next = ST_SWEEP;
            ST_INIT:  w_state_next = ST_SWEEP;
            ST_SWEEP: if (r_cnt == '1) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == ST_SWEEP);
        w_ready = ~w_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_busy)
            r_cnt <= r_cnt + ADDRESS_SIZE'(1);
    end

    assign w_a_wr   = bus.a_req & w_ready & bus.a_we;
    assign w_a_rd   = bus.a_req & w_ready & ~bus.a_we;
    assign w_b_wr   = bus.b_req & w_ready & bus.b_we;
    assign w_b_rd   = bus.b_req & w_ready & ~bus.b_we;
    assign w_a_mask = bus.a_be & {NBYTES{w_a_wr}};
    assign w_b_mask = bus.b_be & {NBYTES{w_b_wr}};

    // The "hi" port is written last so its enabled bytes override the other port on a collision.
    generate
        if (A_PRIORITY != 0) begin : g_a_wins
            assign w_hi_mask  = w_a_mask;
            assign w_hi_addr  = bus.a_addr;
            assign w_hi_wdata = bus.a_wdata;
            assign w_lo_mask  = w_b_mask;
            assign w_lo_addr  = bus.b_addr;
            assign w_lo_wdata = bus.b_wdata;
        end else begin : g_b_wins
            assign w_hi_mask  = w_b_mask;
            assign w_hi_addr  = bus.b_addr;
            assign w_hi_wdata = bus.b_wdata;
            assign w_lo_mask  = w_a_mask;
            assign w_lo_addr  = bus.a_addr;
            assign w_lo_wdata = bus.a_wdata;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_a_q;
            logic [7:0] r_b_q;

            always_ff @(posedge clk) begin
                if (w_busy) begin
                    r_mem[r_cnt] <= '0;
                end else begin
                    if (w_lo_mask[gi]) r_mem[w_lo_addr] <= w_lo_wdata[gi*8 +: 8];
                    if (w_hi_mask[gi]) r_mem[w_hi_addr] <= w_hi_wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_q <= '0;
                    r_b_q <= '0;
                end else begin
                    if (w_a_rd) r_a_q <= r_mem[bus.a_addr];
                    if (w_b_rd) r_b_q <= r_mem[bus.b_addr];
                end
            end

            assign w_a_rdata[gi] = r_a_q;
            assign w_b_rdata[gi] = r_b_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
        end
    end

    assign bus.busy     = w_busy;
    assign bus.a_ready  = w_ready;
    assign bus.b_ready  = w_ready;
    assign bus.a_rdata  = w_a_rdata;
    assign bus.b_rdata  = w_b_rdata;
    assign bus.a_rvalid = r_a_rvalid;
    assign bus.b_rvalid = r_b_rvalid;
endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Bench for dual_port_ram_ctrl: word-level memory model checked every cycle plus literal spot checks.
module tb_dual_port_ram_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   run   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dual_port_ram_ctrl_if #(.ADDRESS_SIZE(4), .WORD_SIZE(32)) bus ();

    dual_port_ram_ctrl #(
        .ADDRESS_SIZE(4), .WORD_SIZE(32), .CLEAR_ON_RESET(1), .A_PRIORITY(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: a 16-word array, a remaining-busy-cycles count and the last read word per port.
    // A sweep is modelled as wiping the whole array at once; no access can observe it mid-sweep.
    logic [31:0] m_mem [16];
    int          m_busy_cnt;
    bit          m_pend;
    bit          m_a_rv, m_b_rv;
    logic [31:0] m_a_rd, m_b_rd;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_cnt <= 0;
            m_pend     <= 1'b1;
            m_a_rv     <= 1'b0;
            m_b_rv     <= 1'b0;
            m_a_rd     <= '0;
            m_b_rd     <= '0;
        end else begin
            m_pend <= 1'b0;
            m_a_rv <= 1'b0;
            m_b_rv <= 1'b0;
            if (m_busy_cnt == 0) begin
                if (bus.a_req && !bus.a_we) begin m_a_rv <= 1'b1; m_a_rd <= m_mem[bus.a_addr]; end
                if (bus.b_req && !bus.b_we) begin m_b_rv <= 1'b1; m_b_rd <= m_mem[bus.b_addr]; end
                if (bus.a_req && bus.a_we && bus.b_req && bus.b_we && bus.a_addr == bus.b_addr) begin
                    m_mem[bus.a_addr] <= merge(merge(m_mem[bus.a_addr], bus.b_wdata, bus.b_be),
                                               bus.a_wdata, bus.a_be);
                end else begin
                    if (bus.a_req && bus.a_we)
                        m_mem[bus.a_addr] <= merge(m_mem[bus.a_addr], bus.a_wdata, bus.a_be);
                    if (bus.b_req && bus.b_we)
                        m_mem[bus.b_addr] <= merge(m_mem[bus.b_addr], bus.b_wdata, bus.b_be);
                end
                if (bus.clr || m_pend) begin
                    m_busy_cnt <= 16;
                    for (int i = 0; i < 16; i++) m_mem[i] <= '0;
                end
            end else begin
                m_busy_cnt <= m_busy_cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("busy",     32'(bus.busy),     32'(m_busy_cnt != 0));
            chk("a_ready",  32'(bus.a_ready),  32'(m_busy_cnt == 0));
            chk("b_ready",  32'(bus.b_ready),  32'(m_busy_cnt == 0));
            chk("a_rvalid", 32'(bus.a_rvalid), 32'(m_a_rv));
            chk("b_rvalid", 32'(bus.b_rvalid), 32'(m_b_rv));
            chk("a_rdata",  bus.a_rdata,       m_a_rd);
            chk("b_rdata",  bus.b_rdata,       m_b_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clr = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_be = '0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_be = '0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic wr(input bit port_b, input logic [3:0] addr, input logic [31:0] d,
                      input logic [3:0] be);
        if (!port_b) begin
            bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = addr; bus.a_wdata = d; bus.a_be = be;
        end else begin
            bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = addr; bus.b_wdata = d; bus.b_be = be;
        end
        step();
        $display("write port=%s addr=%0d data=%h be=%b", port_b ? "B" : "A", addr, d, be);
        idle();
    endtask

    task automatic rd(input bit port_b, input logic [3:0] addr, input logic [31:0] exp,
                      input string nm);
        if (!port_b) begin
            bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = addr;
        end else begin
            bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = addr;
        end
        step();
        if (!port_b) begin
            chk({nm, "_valid"}, 32'(bus.a_rvalid), 32'd1);
            chk(nm, bus.a_rdata, exp);
            $display("read  port=A addr=%0d data=%h", addr, bus.a_rdata);
        end else begin
            chk({nm, "_valid"}, 32'(bus.b_rvalid), 32'd1);
            chk(nm, bus.b_rdata, exp);
            $display("read  port=B addr=%0d data=%h", addr, bus.b_rdata);
        end
        idle();
    endtask

    // Waits (bounded) for busy to rise, then counts the cycles it stays high.
    task automatic wait_sweep(output int n);
        int t;
        t = 0;
        while (!bus.busy && t < 8) begin step(); t++; end
        n = 0;
        while (bus.busy && n < 40) begin step(); n++; end
        $display("sweep busy_cycles=%0d", n);
    endtask

    initial begin
        int n;
        idle();
        #2 rst_n = 1'b0;
        run = 1'b1;
        #1;
        chk("reset_busy",   32'(bus.busy),     32'd0);
        chk("reset_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("reset_rdata",  bus.b_rdata,       32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_sweep(n);
        chk("por_sweep_len", 32'(n), 32'd16);

        // 1: write then read on the other port
        wr(1'b0, 4'd3, 32'hDEADBEEF, 4'hF);
        rd(1'b1, 4'd3, 32'hDEADBEEF, "t1_b_rd");
        // be=0 write leaves the word alone
        wr(1'b0, 4'd3, 32'h0, 4'h0);
        rd(1'b0, 4'd3, 32'hDEADBEEF, "be0_rd");

        // 2: byte enables
        wr(1'b0, 4'd5, 32'h11223344, 4'hF);
        wr(1'b0, 4'd5, 32'hAABBCCDD, 4'b0101);
        rd(1'b0, 4'd5, 32'h11BB33DD, "t2_be_rd");

        // 3: same-address write collision, A wins per enabled byte
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd7; bus.a_wdata = 32'hAAAAAAAA; bus.a_be = 4'b0011;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'd7; bus.b_wdata = 32'hBBBBBBBB; bus.b_be = 4'b1110;
        step();
        $display("write both ports addr=7 collision");
        idle();
        rd(1'b1, 4'd7, 32'hBBBBAAAA, "t3_collide_rd");

        // 4: read-first
        wr(1'b0, 4'd2, 32'h1, 4'hF);
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd2; bus.a_wdata = 32'h2; bus.a_be = 4'hF;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd2;
        step();
        chk("t4_old_word", bus.b_rdata, 32'h1);
        $display("read  port=B addr=2 data=%h (during write)", bus.b_rdata);
        idle();
        rd(1'b0, 4'd2, 32'h2, "t4_new_word");

        // 5: fill, clear with a same-cycle write, reads dropped while busy, clr ignored while busy
        for (int i = 0; i < 16; i++) wr(1'b1, 4'(i), 32'h01010101 * 32'(i + 1), 4'hF);
        rd(1'b0, 4'd9, 32'h0A0A0A0A, "t5_fill_rd");
        bus.clr = 1'b1;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd15; bus.a_wdata = 32'hCAFEF00D; bus.a_be = 4'hF;
        step();
        $display("clear request with write addr=15");
        idle();
        chk("t5_busy", 32'(bus.busy), 32'd1);
        bus.a_req = 1'b1; bus.a_addr = 4'd1;
        bus.b_req = 1'b1; bus.b_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_busy_a_rvalid", 32'(bus.a_rvalid), 32'd0);
            chk("t5_busy_b_rvalid", 32'(bus.b_rvalid), 32'd0);
            chk("t5_busy_ready",    32'(bus.a_ready),  32'd0);
        end
        idle();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        wait_sweep(n);
        chk("t5_sweep_remaining", 32'(n), 32'd11);
        for (int i = 0; i < 16; i++) begin
            rd(1'b0, 4'(i), 32'h0, "t5_zero_a");
            rd(1'b1, 4'(15 - i), 32'h0, "t5_zero_b");
        end

        // 6: reset mid-sweep
        for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), 32'hF0F0F0F0 ^ 32'(i), 4'hF);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",   32'(bus.busy),     32'd0);
        chk("t6_rst_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("t6_rst_ready",  32'(bus.a_ready),  32'd1);
        $display("reset asserted mid-sweep");
        repeat (2) step();
        rst_n = 1'b1;
        wait_sweep(n);
        chk("t6_sweep_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) rd(1'b1, 4'(i), 32'h0, "t6_zero");

        step();
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
